// File: rtl/cpu_control_fsm.sv
// ----------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control unit for the 16-bit CPU datapath. Sequences each
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives the ALU
// control interface, datapath enables, mux selects and the memory handshake.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Opcode, Funct       instruction fields from IR (valid from DECODE on)
//   Zero                ALU zero flag, used only in BEQ EXEC
//   MemReady            memory access complete, used only in FETCH / MEM
//   ALUCtrl/BInvert/CIN ALU operation controls
//   ALUSrcA/ALUSrcB     ALU operand selects
//   PCWrite/PCSource    PC load enable and next-PC select
//   IRWrite             IR load enable
//   MemRead/MemWrite    memory requests, IorD selects the address source
//   RegWrite/RegDst/MemToReg  register file write controls
//   Illegal             one-cycle pulse in DECODE on an undefined opcode/funct
//
// Outputs are decoded from the state register and the latched op register;
// the only input-dependent terms are the MemReady/Zero qualified enables,
// the DECODE dispatch, and the reset override, as the handshake requires.
// ----------------------------------------------------------------------------
module cpu_control_fsm (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic [2:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [2:0] ALUCtrl,
    output logic       BInvert,
    output logic       CIN,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       Illegal
);

    localparam int unsigned OP_W = 4;
    localparam int unsigned FN_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b0100;
    localparam logic [OP_W-1:0] OP_LW    = 4'b0110;
    localparam logic [OP_W-1:0] OP_SW    = 4'b0111;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'b1000;
    localparam logic [OP_W-1:0] OP_J     = 4'b1001;

    localparam logic [2:0] ALU_ADD = 3'b010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [FN_W-1:0] funct_q;

    // Instruction legality of the live IR fields, evaluated in DECODE.
    function automatic logic is_legal(input logic [OP_W-1:0] op,
                                      input logic [FN_W-1:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: ok = (fn <= 3'b101);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type funct to {ALUCtrl, BInvert, CIN}; SUB/SLT use invert + carry-in.
    function automatic logic [4:0] rtype_alu(input logic [FN_W-1:0] fn);
        logic [4:0] c;
        case (fn)
            3'b000:  c = {3'b000, 1'b0, 1'b0};
            3'b001:  c = {3'b001, 1'b0, 1'b0};
            3'b010:  c = {3'b010, 1'b0, 1'b0};
            3'b011:  c = {3'b010, 1'b1, 1'b1};
            3'b100:  c = {3'b011, 1'b0, 1'b0};
            3'b101:  c = {3'b101, 1'b1, 1'b1};
            default: c = 5'b00000;
        endcase
        return c;
    endfunction

    // State and latched op register; the op is captured only on DECODE->EXEC.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && state_d == S_EXEC) begin
                op_q    <= Opcode;
                funct_q <= Funct;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = S_FETCH;
        ALUCtrl  = 3'b000;
        BInvert  = 1'b0;
        CIN      = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        PCWrite  = 1'b0;
        PCSource = PCSRC_ALU;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        Illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_ONE;
                ALUCtrl  = ALU_ADD;
                IRWrite  = MemReady;
                PCWrite  = MemReady;
                state_d  = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes PC + imm into ALUOut as the branch target.
                ALUSrcB = SRCB_IMM;
                ALUCtrl = ALU_ADD;
                if (!is_legal(Opcode, Funct)) begin
                    Illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (Opcode == OP_J) begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JMP;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (op_q)
                    OP_RTYPE: begin
                        ALUSrcB                  = SRCB_REG;
                        {ALUCtrl, BInvert, CIN}  = rtype_alu(funct_q);
                        state_d                  = S_WB;
                    end
                    OP_ADDI: begin
                        ALUSrcB = SRCB_IMM;
                        ALUCtrl = ALU_ADD;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcB = SRCB_IMM;
                        ALUCtrl = ALU_ADD;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        ALUSrcB  = SRCB_REG;
                        ALUCtrl  = ALU_ADD;
                        BInvert  = 1'b1;
                        CIN      = 1'b1;
                        PCSource = PCSRC_OUT;
                        PCWrite  = Zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
                if (!MemReady) begin
                    state_d = S_MEM;
                end else begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_RTYPE);
                MemToReg = (op_q == OP_LW);
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts any access in the same cycle.
        if (Reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Directed bench for cpu_control_fsm. Each cycle drives inputs just after the
// rising edge and compares the packed control word on the falling edge
// against a hand-written expected word.
// Packed order: ALUCtrl[3] BInvert CIN ALUSrcA ALUSrcB[2] PCWrite PCSource[2]
//               IRWrite MemRead MemWrite IorD RegWrite RegDst MemToReg Illegal
// ----------------------------------------------------------------------------
module tb_cpu_control_fsm;

    logic       Clock;
    logic       Reset;
    logic [3:0] Opcode;
    logic [2:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic [2:0] ALUCtrl;
    logic       BInvert;
    logic       CIN;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       Illegal;

    int n_checks;
    int n_fail;

    cpu_control_fsm dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Opcode   (Opcode),
        .Funct    (Funct),
        .Zero     (Zero),
        .MemReady (MemReady),
        .ALUCtrl  (ALUCtrl),
        .BInvert  (BInvert),
        .CIN      (CIN),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCWrite  (PCWrite),
        .PCSource (PCSource),
        .IRWrite  (IRWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .Illegal  (Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [18:0] obs;
    assign obs = {ALUCtrl, BInvert, CIN, ALUSrcA, ALUSrcB, PCWrite, PCSource,
                  IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemToReg, Illegal};

    function automatic logic [18:0] pk(
        input logic [2:0] ac, input logic bi, input logic ci, input logic sa,
        input logic [1:0] sb, input logic pw, input logic [1:0] ps,
        input logic irw, input logic mrd, input logic mwr, input logic iord,
        input logic rw, input logic rd, input logic m2r, input logic ill);
        return {ac, bi, ci, sa, sb, pw, ps, irw, mrd, mwr, iord, rw, rd, m2r, ill};
    endfunction

    localparam logic [18:0] E_FETCH     = pk(3'b010,0,0,0,2'b01,1,2'b00,1,1,0,0,0,0,0,0);
    localparam logic [18:0] E_FETCH_W   = pk(3'b010,0,0,0,2'b01,0,2'b00,0,1,0,0,0,0,0,0);
    localparam logic [18:0] E_FETCH_RST = pk(3'b010,0,0,0,2'b01,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_DEC       = pk(3'b010,0,0,0,2'b10,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_DEC_J     = pk(3'b010,0,0,0,2'b10,1,2'b10,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_DEC_ILL   = pk(3'b010,0,0,0,2'b10,0,2'b00,0,0,0,0,0,0,0,1);
    localparam logic [18:0] E_EX_SUB    = pk(3'b010,1,1,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_EX_SLT    = pk(3'b101,1,1,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_EX_XOR    = pk(3'b011,0,0,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_EX_IMM    = pk(3'b010,0,0,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_EX_BEQ_T  = pk(3'b010,1,1,1,2'b00,1,2'b01,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_EX_BEQ_N  = pk(3'b010,1,1,1,2'b00,0,2'b01,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_MEM_LW    = pk(3'b000,0,0,0,2'b00,0,2'b00,0,1,0,1,0,0,0,0);
    localparam logic [18:0] E_MEM_SW    = pk(3'b000,0,0,0,2'b00,0,2'b00,0,0,1,1,0,0,0,0);
    localparam logic [18:0] E_MEM_RST   = pk(3'b000,0,0,0,2'b00,0,2'b00,0,0,0,1,0,0,0,0);
    localparam logic [18:0] E_WB_R      = pk(3'b000,0,0,0,2'b00,0,2'b00,0,0,0,0,1,1,0,0);
    localparam logic [18:0] E_WB_I      = pk(3'b000,0,0,0,2'b00,0,2'b00,0,0,0,0,1,0,0,0);
    localparam logic [18:0] E_WB_LW     = pk(3'b000,0,0,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0);

    task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // One clock cycle: apply inputs, compare on the falling edge, then advance.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] op,
                       input logic [2:0] fn, input logic z, input logic mr,
                       input logic [18:0] want);
        Reset    = rst;
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        MemReady = mr;
        @(negedge Clock);
        check_eq(tag, obs, want);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Opcode   = 4'b0000;
        Funct    = 3'b000;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(posedge Clock);
        #1;

        // Reset: enables forced low even with MemReady high
        cyc("rst0",       1, 4'b0000, 3'b000, 0, 1, E_FETCH_RST);
        cyc("rst1",       1, 4'b0000, 3'b000, 0, 1, E_FETCH_RST);

        // SUB; IR fields change after DECODE to show the latched copy is used
        cyc("sub_fetch",  0, 4'b0000, 3'b011, 0, 1, E_FETCH);
        cyc("sub_dec",    0, 4'b0000, 3'b011, 0, 1, E_DEC);
        cyc("sub_exec",   0, 4'b1001, 3'b000, 1, 0, E_EX_SUB);
        cyc("sub_wb",     0, 4'b0110, 3'b100, 0, 0, E_WB_R);

        // LW with three MemReady-low cycles in MEM: 8 cycles total
        cyc("lw_fetch",   0, 4'b0110, 3'b000, 0, 1, E_FETCH);
        cyc("lw_dec",     0, 4'b0110, 3'b000, 0, 1, E_DEC);
        cyc("lw_exec",    0, 4'b0110, 3'b000, 0, 0, E_EX_IMM);
        cyc("lw_mem_w0",  0, 4'b0110, 3'b000, 0, 0, E_MEM_LW);
        cyc("lw_mem_w1",  0, 4'b0110, 3'b000, 0, 0, E_MEM_LW);
        cyc("lw_mem_w2",  0, 4'b0110, 3'b000, 0, 0, E_MEM_LW);
        cyc("lw_mem_rdy", 0, 4'b0110, 3'b000, 0, 1, E_MEM_LW);
        cyc("lw_wb",      0, 4'b0110, 3'b000, 0, 1, E_WB_LW);

        // BEQ taken then not taken
        cyc("beqt_fetch", 0, 4'b1000, 3'b000, 0, 1, E_FETCH);
        cyc("beqt_dec",   0, 4'b1000, 3'b000, 0, 1, E_DEC);
        cyc("beqt_exec",  0, 4'b1000, 3'b000, 1, 0, E_EX_BEQ_T);
        cyc("beqn_fetch", 0, 4'b1000, 3'b000, 1, 1, E_FETCH);
        cyc("beqn_dec",   0, 4'b1000, 3'b000, 1, 1, E_DEC);
        cyc("beqn_exec",  0, 4'b1000, 3'b000, 0, 1, E_EX_BEQ_N);

        // Illegal opcode, then illegal funct
        cyc("ill_fetch",  0, 4'b1111, 3'b000, 0, 1, E_FETCH);
        cyc("ill_dec",    0, 4'b1111, 3'b000, 0, 1, E_DEC_ILL);
        cyc("illf_fetch", 0, 4'b0000, 3'b110, 0, 1, E_FETCH);
        cyc("illf_dec",   0, 4'b0000, 3'b110, 0, 1, E_DEC_ILL);

        // SW with reset landing in the MEM wait
        cyc("sw_fetch",   0, 4'b0111, 3'b000, 0, 1, E_FETCH);
        cyc("sw_dec",     0, 4'b0111, 3'b000, 0, 1, E_DEC);
        cyc("sw_exec",    0, 4'b0111, 3'b000, 0, 1, E_EX_IMM);
        cyc("sw_mem_w",   0, 4'b0111, 3'b000, 0, 0, E_MEM_SW);
        cyc("sw_mem_rst", 1, 4'b0111, 3'b000, 0, 0, E_MEM_RST);
        cyc("post_rst",   0, 4'b0100, 3'b000, 0, 1, E_FETCH);

        // ADDI (fetch already above)
        cyc("addi_dec",   0, 4'b0100, 3'b000, 0, 1, E_DEC);
        cyc("addi_exec",  0, 4'b0100, 3'b000, 0, 1, E_EX_IMM);
        cyc("addi_wb",    0, 4'b0100, 3'b000, 0, 1, E_WB_I);

        // SLT and XOR
        cyc("slt_fetch",  0, 4'b0000, 3'b101, 0, 1, E_FETCH);
        cyc("slt_dec",    0, 4'b0000, 3'b101, 0, 1, E_DEC);
        cyc("slt_exec",   0, 4'b0000, 3'b101, 0, 1, E_EX_SLT);
        cyc("slt_wb",     0, 4'b0000, 3'b101, 0, 1, E_WB_R);
        cyc("xor_fetch",  0, 4'b0000, 3'b100, 0, 1, E_FETCH);
        cyc("xor_dec",    0, 4'b0000, 3'b100, 0, 1, E_DEC);
        cyc("xor_exec",   0, 4'b0000, 3'b100, 0, 1, E_EX_XOR);
        cyc("xor_wb",     0, 4'b0000, 3'b100, 0, 1, E_WB_R);

        // J with one FETCH wait cycle, then next FETCH
        cyc("j_fetch_w",  0, 4'b1001, 3'b000, 0, 0, E_FETCH_W);
        cyc("j_fetch",    0, 4'b1001, 3'b000, 0, 1, E_FETCH);
        cyc("j_dec",      0, 4'b1001, 3'b000, 0, 1, E_DEC_J);
        cyc("j_next",     0, 4'b0000, 3'b000, 0, 1, E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
